// File: rtl/dmem_store_buffer_pkg.sv
// Shared definitions for the data-memory store buffer: FSM encoding and default sizes.
package dmem_store_buffer_pkg;

   localparam int DEPTH_DEF = 4;
   localparam int AW_DEF    = 32;
   localparam int DW_DEF    = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_store_buffer_store_queue.sv
// Circular FIFO of posted stores (word address + data) with a youngest-match lookup
// used for store-to-load forwarding.
module dmem_store_buffer_store_queue #(
   parameter int DEPTH = 4,
   parameter int WW    = 30,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [WW-1:0] push_addr,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [WW-1:0] head_addr,
   output logic [DW-1:0] head_data,
   output logic          full,
   output logic          empty,
   input  logic [WW-1:0] lookup_addr,
   output logic          lookup_hit,
   output logic [DW-1:0] lookup_data
);

   localparam int PW = $clog2(DEPTH);

   logic [WW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    tail_q;
   logic [PW:0]      count_q;
   logic [PW-1:0]    idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (pop) begin
            head_q          <= head_q + 1'b1;
            valid_q[head_q] <= 1'b0;
         end
         if (push) begin
            addr_q[tail_q]  <= push_addr;
            data_q[tail_q]  <= push_data;
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Walk oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      idx         = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (valid_q[idx] && (addr_q[idx] == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = data_q[idx];
         end
      end
   end

   assign head_addr = addr_q[head_q];
   assign head_data = data_q[head_q];
   assign full      = (count_q == (PW+1)'(DEPTH));
   assign empty     = (count_q == '0);

endmodule

// File: rtl/dmem_store_buffer.sv
// MEM-stage data-memory front end: posts stores into a FIFO drained over req/ack,
// forwards loads from buffered stores, and stalls the pipeline on load misses or a full FIFO.
module dmem_store_buffer
   import dmem_store_buffer_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   input  logic          mem_write,
   input  logic          mem_read,
   output logic [DW-1:0] rdata,
   output logic          stall,
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_ack,
   input  logic [DW-1:0] bus_rdata
);

   // state    | meaning
   // ST_IDLE  | no bus transaction; picks load miss first, else drains head
   // ST_DRAIN | write of FIFO head outstanding; pops on ack
   // ST_LOAD  | read for stalled load outstanding; data returned on ack

   localparam int WW = AW - 2;

   state_t        state_q, state_d;
   logic          q_full, q_empty, hit;
   logic [WW-1:0] head_addr;
   logic [DW-1:0] head_data, fwd_data;
   logic          push, pop, load_miss, read_done;
   logic          unused_addr_lsbs;

   assign unused_addr_lsbs = ^addr[1:0];

   assign push      = mem_write && !q_full;
   assign pop       = (state_q == ST_DRAIN) && bus_ack;
   assign load_miss = mem_read && !mem_write && !hit;
   assign read_done = (state_q == ST_LOAD) && bus_ack;

   dmem_store_buffer_store_queue #(
      .DEPTH (DEPTH),
      .WW    (WW),
      .DW    (DW)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_addr   (addr[AW-1:2]),
      .push_data   (wdata),
      .pop         (pop),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .full        (q_full),
      .empty       (q_empty),
      .lookup_addr (addr[AW-1:2]),
      .lookup_hit  (hit),
      .lookup_data (fwd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (load_miss)     state_d = ST_LOAD;
            else if (!q_empty) state_d = ST_DRAIN;
         end
         ST_DRAIN: if (bus_ack) state_d = ST_IDLE;
         ST_LOAD:  if (bus_ack) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      stall = (mem_write && q_full) || (load_miss && !read_done);
      rdata = read_done ? bus_rdata : fwd_data;
   end

   // Bus fields only change when a transaction is launched, so they hold while bus_req is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
      end else if (state_q == ST_IDLE && state_d == ST_LOAD) begin
         bus_req  <= 1'b1;
         bus_we   <= 1'b0;
         bus_addr <= {addr[AW-1:2], 2'b00};
      end else if (state_q == ST_IDLE && state_d == ST_DRAIN) begin
         bus_req   <= 1'b1;
         bus_we    <= 1'b1;
         bus_addr  <= {head_addr, 2'b00};
         bus_wdata <= head_data;
      end else if (state_q != ST_IDLE && bus_ack) begin
         bus_req <= 1'b0;
      end
   end

   a_no_read_write: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: random and directed stores/loads against an
// architectural memory model and a RAM slave with variable ack latency.
module tb_dmem_store_buffer;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [29:0] w;
      logic [31:0] d;
   } st_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0, wdata = '0;
   logic        mem_write = 1'b0, mem_read = 1'b0;
   logic [31:0] rdata;
   logic        stall, bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic        slave_ack = 1'b0, stray_ack = 1'b0;
   logic        bus_ack;
   logic [31:0] bus_rdata = '0;

   assign bus_ack = slave_ack | stray_ack;

   int  n_tests = 0, n_fail = 0;
   bit  hold = 1'b0;
   int  fixed_lat = -1;

   st_t         pend_q[$];
   logic [31:0] exp_rd_q[$];
   logic [31:0] golden [logic [29:0]];
   logic [31:0] ram    [logic [29:0]];

   dmem_store_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .wdata     (wdata),
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .rdata     (rdata),
      .stall     (stall),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(logic [29:0] w);
      return {w[15:0] ^ 16'hA5C3, ~w[15:0]};
   endfunction

   function automatic logic [31:0] gold_rd(logic [29:0] w);
      return golden.exists(w) ? golden[w] : init_val(w);
   endfunction

   function automatic logic [31:0] ram_rd(logic [29:0] w);
      return ram.exists(w) ? ram[w] : init_val(w);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Monitor: compares stall/rdata against the architectural model whenever a request is presented.
   always @(negedge clk) begin
      bit match;
      if (!rst) begin
         if (mem_write) begin
            check("store_stall", 32'(stall), 32'(pend_q.size() == DEPTH));
         end else if (mem_read) begin
            match = 1'b0;
            foreach (pend_q[i]) if (pend_q[i].w == addr[31:2]) match = 1'b1;
            check("load_stall", 32'(stall), 32'(!(match || (bus_ack && !bus_we))));
            if (!stall) begin
               if (exp_rd_q.size() == 0) fail_now("load_unexpected");
               else check("load_data", rdata, exp_rd_q.pop_front());
            end
         end
      end
   end

   // RAM slave: variable latency, one-cycle ack, checks drain order and bus stability.
   int          wait_cnt = -1;
   logic        last_we = 1'b0, cap_we = 1'b0;
   logic [31:0] cap_addr = '0, cap_wdata = '0;

   always @(posedge clk) begin
      #2;
      if (rst) begin
         slave_ack = 1'b0;
         wait_cnt  = -1;
      end else if (slave_ack) begin
         slave_ack = 1'b0;
         check("req_drop", 32'(bus_req), 32'(0));
         if (last_we && pend_q.size() > 0) void'(pend_q.pop_front());
      end else if (bus_req && !hold) begin
         if (wait_cnt < 0) begin
            wait_cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
            cap_we    = bus_we;
            cap_addr  = bus_addr;
            cap_wdata = bus_wdata;
         end
         if (wait_cnt == 0) begin
            check("bus_addr_stable", bus_addr, cap_addr);
            check("bus_we_stable", 32'(bus_we), 32'(cap_we));
            slave_ack = 1'b1;
            last_we   = bus_we;
            wait_cnt  = -1;
            if (bus_we) begin
               check("bus_wdata_stable", bus_wdata, cap_wdata);
               if (pend_q.size() == 0) fail_now("drain_unexpected");
               else begin
                  check("drain_addr", bus_addr, {pend_q[0].w, 2'b00});
                  check("drain_data", bus_wdata, pend_q[0].d);
               end
               ram[bus_addr[31:2]] = bus_wdata;
            end else begin
               check("read_addr", bus_addr, {addr[31:2], 2'b00});
               bus_rdata = ram_rd(bus_addr[31:2]);
            end
         end else begin
            wait_cnt--;
         end
      end
   end

   // Driver tasks start and end at posedge+1.
   task automatic do_store(logic [31:0] a, logic [31:0] d);
      int k;
      mem_write = 1'b1; mem_read = 1'b0; addr = a; wdata = d;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!stall) break;
      end
      if (k == 300) begin
         fail_now("store_timeout");
         mem_write = 1'b0;
         return;
      end
      @(posedge clk); #1;
      pend_q.push_back(st_t'{a[31:2], d});
      golden[a[31:2]] = d;
      mem_write = 1'b0;
   endtask

   task automatic do_load(logic [31:0] a, output int waited);
      int k;
      exp_rd_q.push_back(gold_rd(a[31:2]));
      mem_read = 1'b1; mem_write = 1'b0; addr = a;
      waited = 0;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!stall) break;
         waited++;
      end
      if (k == 300) begin
         fail_now("load_timeout");
         if (exp_rd_q.size() > 0) void'(exp_rd_q.pop_back());
      end
      @(posedge clk); #1;
      mem_read = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_drained();
      for (int k = 0; k < 400; k++) begin
         if (pend_q.size() == 0 && !bus_req) return;
         @(posedge clk); #1;
      end
      fail_now("drain_timeout");
   endtask

   task automatic summary();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired at %0t", $time);
      summary();
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int r;
      logic [31:0] a;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_bus_req", 32'(bus_req), 32'(0));
      check("rst_bus_we", 32'(bus_we), 32'(0));
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_bus_wdata", bus_wdata, 32'h0);
      check("rst_stall", 32'(stall), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      idle(1);

      // 1: forward from a store that is about to drain
      hold = 1'b1;
      do_store(32'h40, 32'hDEADBEEF);
      do_load(32'h40, w);
      check("t1_fwd_wait", 32'(w), 32'(0));
      check("t1_bus_req", 32'(bus_req), 32'(1));
      check("t1_bus_we", 32'(bus_we), 32'(1));
      check("t1_bus_addr", bus_addr, 32'h40);

      // 2: youngest match wins
      do_store(32'h10, 32'h1);
      do_store(32'h10, 32'h2);
      do_load(32'h12, w);
      check("t2_bus_we_held", 32'(bus_we), 32'(1));
      check("t2_bus_addr_held", bus_addr, 32'h40);
      hold = 1'b0;
      wait_drained();

      // 3: fill the FIFO, fifth store stalls until the first drain ack
      hold = 1'b1;
      for (int i = 0; i < 4; i++) do_store(32'h500 + 32'(i * 4), 32'hA000 + 32'(i));
      fork
         do_store(32'h520, 32'hA004);
         begin
            repeat (4) @(negedge clk);
            hold = 1'b0;
         end
      join
      wait_drained();

      // 4: load miss with a fixed 3-cycle stall
      ram[30'h20] = 32'h12345678;
      golden[30'h20] = 32'h12345678;
      fixed_lat = 2;
      do_load(32'h80, w);
      check("t4_stall_cycles", 32'(w), 32'(3));
      fixed_lat = -1;

      // 5: load miss behind an in-flight drain
      hold = 1'b1;
      do_store(32'h200, 32'hCAFE0001);
      idle(2);
      fork
         do_load(32'h100, w);
         begin
            repeat (3) @(negedge clk);
            hold = 1'b0;
         end
      join
      wait_drained();

      // 6: reset mid-drain abandons the queue; stray ack afterwards is ignored
      hold = 1'b1;
      do_store(32'h300, 32'h11111111);
      do_store(32'h304, 32'h22222222);
      do_store(32'h308, 32'h33333333);
      idle(2);
      check("t6_pre_rst_req", 32'(bus_req), 32'(1));
      #3 rst = 1'b1;
      #1 check("t6_rst_req", 32'(bus_req), 32'(0));
      pend_q.delete();
      golden = ram;
      @(posedge clk); #1;
      rst = 1'b0;
      stray_ack = 1'b1;
      @(posedge clk); #1;
      stray_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t6_no_drain", 32'(bus_req), 32'(0));
         idle(1);
      end
      hold = 1'b0;
      do_load(32'h304, w);

      // Random traffic
      for (int i = 0; i < 250; i++) begin
         r = int'($urandom_range(0, 99));
         a = 32'h1000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
         if (r < 45)      do_store(a, $urandom);
         else if (r < 80) do_load(a, w);
         else             idle(int'($urandom_range(1, 3)));
      end
      wait_drained();
      idle(3);

      foreach (golden[k]) check("final_mem", ram_rd(k), golden[k]);
      if (exp_rd_q.size() != 0) fail_now("loads_outstanding");

      summary();
      $finish;
   end

endmodule
